// File: rtl/hermitian_inserter_bram_pkg.sv
// hermitian_pkg
// Shared definitions for the Hermitian inserter: FSM state encoding, frame
// geometry for the default build (64-point frame, 16-bit I/Q), {I,Q} packing
// helpers and the conjugate negation used on the upper half of the frame.
// Optional feature macro: HERMITIAN_INSERTER_SAT_EN
//   defined   -> negated Q saturates (-2^(DW-1) becomes +2^(DW-1)-1)
//   undefined -> plain two's-complement negation (-2^(DW-1) wraps to itself)
package hermitian_pkg;

   localparam int FFT_N = 64;
   localparam int IQ_DW = 16;

   localparam int HALF = FFT_N / 2;
   localparam int NSYM = FFT_N / 2 - 1;
   localparam int AW   = $clog2(FFT_N / 2);

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      EMIT_LO = 2'd1,
      EMIT_HI = 2'd2
   } state_t;

   function automatic logic [2*IQ_DW-1:0] iq_pack(input logic [IQ_DW-1:0] i,
                                                  input logic [IQ_DW-1:0] q);
      return {i, q};
   endfunction

   function automatic logic [IQ_DW-1:0] iq_i(input logic [2*IQ_DW-1:0] s);
      return s[2*IQ_DW-1:IQ_DW];
   endfunction

   function automatic logic [IQ_DW-1:0] iq_q(input logic [2*IQ_DW-1:0] s);
      return s[IQ_DW-1:0];
   endfunction

   // Negation is formed one bit wider so the single overflow case
   // (most negative input) is visible as a sign/MSB disagreement.
   function automatic logic [IQ_DW-1:0] neg_q(input logic [IQ_DW-1:0] q);
      logic [IQ_DW:0] n;
      n = -{q[IQ_DW-1], q};
`ifdef HERMITIAN_INSERTER_SAT_EN
      if (n[IQ_DW] != n[IQ_DW-1])
         return {1'b0, {(IQ_DW-1){1'b1}}};
`endif
      return n[IQ_DW-1:0];
   endfunction

endpackage

// File: rtl/hermitian_inserter_bram_buff_ins.sv
// bram_buff_ins
// Single-port symbol buffer, DEPTH x W, synchronous read with one cycle of
// latency and write-first behaviour. Written as a plain registered-read
// array so it maps onto block RAM.
// Ports:
//   clk    clock
//   we     write enable
//   addr   word address (shared by read and write)
//   wdata  write data
//   rdata  registered read data (equals wdata on a write cycle)
module bram_buff_ins #(
   parameter int DEPTH = 31,
   parameter int W     = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
         rdata     <= wdata;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/hermitian_inserter_bram.sv
// hermitian_inserter_bram
// Buffers one frame of N/2-1 complex symbols, then streams an N-point
// Hermitian-symmetric frame: X[0]=0, X[k]=d[k-1] (k=1..N/2-1), X[N/2]=0,
// X[N-k]=conj(X[k]). Read path: BRAM (1 cycle) -> output register + skid.
// Optional feature macro: HERMITIAN_INSERTER_SAT_EN (saturating Q negation,
// implemented in hermitian_pkg::neg_q).
// N and DW must match hermitian_pkg::FFT_N / IQ_DW; the helpers are sized there.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_ready   input symbol handshake, s_data = {I, Q}
//   m_valid/m_ready   output sample handshake, m_data = {I, Q}
//   m_last            high with sample N-1
//   busy              high while emitting a frame
//
// state   | meaning
// --------+------------------------------------------------------------
// FILL    | accepting symbols into BRAM at wr_cnt
// EMIT_LO | issuing k=0..N/2 (k=0 and N/2 are zero, others read k-1)
// EMIT_HI | issuing k=N/2+1..N-1 from N-k-1, conjugated; wait for m_last
module hermitian_inserter_bram
   import hermitian_pkg::*;
#(
   parameter int N  = FFT_N,
   parameter int DW = IQ_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [2*DW-1:0] s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [2*DW-1:0] m_data,
   output logic          m_last,
   output logic          busy
);

   localparam int KW = $clog2(N);

   state_t state, state_nx;

   logic [AW-1:0]   wr_cnt;
   logic [KW-1:0]   rd_k;
   logic            iss_done;
   logic            s_ready_r;

   logic            accept, last_sym, pop, issue, issue_ok;
   logic            k_is_zero, k_is_half, k_is_last;
   logic [2:0]      load;

   logic [AW-1:0]   bram_addr, rd_addr;
   logic [2*DW-1:0] rdata;

   logic            s1_v, s1_zero, s1_conj, s1_last;
   logic [2*DW-1:0] s1_data;

   logic            head_v, head_l, skid_v, skid_l;
   logic [2*DW-1:0] head_d, skid_d;

   assign accept    = s_valid & s_ready_r;
   assign last_sym  = (wr_cnt == AW'(NSYM - 1));
   assign pop       = head_v & m_ready;

   assign k_is_zero = (rd_k == KW'(0));
   assign k_is_half = (rd_k == KW'(HALF));
   assign k_is_last = (rd_k == KW'(N - 1));

   // Issue only if the sample can never overflow output+skid: entries held
   // plus the one in the BRAM stage, less this cycle's pop, must leave room.
   assign load     = {2'b00, head_v} + {2'b00, skid_v} + {2'b00, s1_v};
   assign issue_ok = (load <= (3'd1 + {2'b00, pop}));
   assign issue    = issue_ok &
                     ((state == EMIT_LO) | ((state == EMIT_HI) & ~iss_done));

   // Address arithmetic wraps modulo N/2, so the low AW bits suffice.
   assign rd_addr   = (state == EMIT_HI) ? (AW'(HALF - 1) - rd_k[AW-1:0])
                                         : (rd_k[AW-1:0] - AW'(1));
   assign bram_addr = (state == FILL) ? wr_cnt : rd_addr;

   bram_buff_ins #(
      .DEPTH (NSYM),
      .W     (2*DW),
      .AW    (AW)
   ) u_buff (
      .clk   (clk),
      .we    (accept & ~rst),
      .addr  (bram_addr),
      .wdata (s_data),
      .rdata (rdata)
   );

   always_comb begin
      state_nx = state;
      case (state)
         FILL:    if (accept && last_sym)   state_nx = EMIT_LO;
         EMIT_LO: if (issue && k_is_half)   state_nx = EMIT_HI;
         EMIT_HI: if (pop && head_l)        state_nx = FILL;
         default:                           state_nx = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nx;
   end

   always_comb begin
      s1_data = rdata;
      if (s1_zero)
         s1_data = '0;
      else if (s1_conj)
         s1_data = iq_pack(iq_i(rdata), neg_q(iq_q(rdata)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt    <= '0;
         rd_k      <= '0;
         iss_done  <= 1'b0;
         s_ready_r <= 1'b0;
         s1_v      <= 1'b0;
         s1_zero   <= 1'b0;
         s1_conj   <= 1'b0;
         s1_last   <= 1'b0;
         head_v    <= 1'b0;
         head_l    <= 1'b0;
         head_d    <= '0;
         skid_v    <= 1'b0;
         skid_l    <= 1'b0;
         skid_d    <= '0;
      end else begin
         s_ready_r <= (state_nx == FILL);

         if (accept)
            wr_cnt <= last_sym ? '0 : wr_cnt + AW'(1);

         if (issue)
            rd_k <= rd_k + KW'(1);

         iss_done <= (state == FILL) ? 1'b0 : (iss_done | (issue & k_is_last));

         s1_v    <= issue;
         s1_zero <= k_is_zero | k_is_half;
         s1_conj <= (state == EMIT_HI);
         s1_last <= k_is_last;

         if (pop) begin
            if (skid_v) begin
               head_v <= 1'b1;
               head_d <= skid_d;
               head_l <= skid_l;
               skid_v <= s1_v;
               if (s1_v) begin
                  skid_d <= s1_data;
                  skid_l <= s1_last;
               end
            end else begin
               head_v <= s1_v;
               if (s1_v) begin
                  head_d <= s1_data;
                  head_l <= s1_last;
               end
            end
         end else if (!head_v) begin
            head_v <= s1_v;
            if (s1_v) begin
               head_d <= s1_data;
               head_l <= s1_last;
            end
         end else if (s1_v) begin
            skid_v <= 1'b1;
            skid_d <= s1_data;
            skid_l <= s1_last;
         end
      end
   end

   assign s_ready = s_ready_r;
   assign m_valid = head_v;
   assign m_data  = head_d;
   assign m_last  = head_v & head_l;
   assign busy    = (state != FILL);

endmodule

// File: tb/tb_hermitian_inserter_bram.sv
module tb_hermitian_inserter_bram;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid, s_ready, m_valid, m_ready, m_last, busy;
   logic [31:0] s_data, m_data;

   hermitian_inserter_bram #(.N(64), .DW(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] sym  [31];
   logic [31:0] expv [64];
   logic [31:0] got  [64];
   bit          pat  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   int busy_run  = 0;
   int busy_last = 0;

   always @(negedge clk) begin
      if (busy) begin
         busy_run <= busy_run + 1;
      end else begin
         if (busy_run != 0) busy_last <= busy_run;
         busy_run <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] negq(input logic [15:0] q);
      if (q == 16'h8000) begin
`ifdef HERMITIAN_INSERTER_SAT_EN
         return 16'h7fff;
`else
         return 16'h8000;
`endif
      end
      return ~q + 16'd1;
   endfunction

   task automatic load_frame(input int mode);
      for (int i = 0; i < 31; i++) begin
         if (mode == 2) sym[i] = {16'(i * 3 + 7), 16'(i * 11 - 200)};
         else           sym[i] = {16'(i + 1), 16'(-(i + 1))};
      end
      if (mode == 1) sym[0] = {16'd100, 16'h8000};
      expv[0]  = 32'h0;
      expv[32] = 32'h0;
      for (int k = 1; k < 32; k++) expv[k] = sym[k-1];
      for (int k = 33; k < 64; k++) expv[k] = {expv[64-k][31:16], negq(expv[64-k][15:0])};
   endtask

   task automatic send_frame(input int n);
      int   i = 0;
      int   guard = 0;
      logic rdy;
      while (i < n && guard < 200) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = sym[i];
         rdy     = s_ready;
         if (guard == 0) chk("ready_at_start", 32'(rdy), 32'd1);
         @(posedge clk);
         if (rdy) i++;
         guard++;
      end
      chk("send_count", i, n);
   endtask

   task automatic recv_frame(input bit toggle, input bit hold_sv, input logic [31:0] hold_data);
      int          k = 0;
      int          cyc = 0;
      int          first = -1;
      int          lastc = -1;
      bit          pend = 1'b0;
      bit          saw_rdy = 1'b0;
      logic [31:0] held = '0;
      while (k < 64 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         s_valid = hold_sv;
         s_data  = hold_data;
         m_ready = toggle ? pat[cyc % 8] : 1'b1;
         if (s_ready) saw_rdy = 1'b1;
         if (cyc == 1) chk("busy_rise", 32'(busy), 32'd1);
         if (pend) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", m_data, held);
         end
         if (m_valid) begin
            if (first < 0) first = cyc;
            if (m_ready) begin
               got[k] = m_data;
               chk($sformatf("data_k%0d", k), m_data, expv[k]);
               chk($sformatf("last_k%0d", k), 32'(m_last), 32'(k == 63));
               k++;
               pend  = 1'b0;
               lastc = cyc;
            end else begin
               held = m_data;
               pend = 1'b1;
            end
         end
      end
      chk("frame_count", k, 64);
      chk("first_valid_cycle", first, 3);
      chk("no_ready_in_emit", 32'(saw_rdy), 32'd0);
      if (!toggle) chk("span", lastc - first, 63);
      s_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", m_data, 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(s_ready), 32'd1);

      // Frame A, m_ready held high
      load_frame(0);
      send_frame(31);
      recv_frame(1'b0, 1'b0, 32'h0);
      chk("x0", got[0], 32'h0000_0000);
      chk("x5", got[5], 32'h0005_FFFB);
      chk("x32", got[32], 32'h0000_0000);
      chk("x59", got[59], 32'h0005_0005);
      @(negedge clk);
      chk("busy_fall", 32'(busy), 32'd0);
      @(negedge clk);
      chk("busy_len_a", busy_last, 66);

      // Frame A again under backpressure
      send_frame(31);
      recv_frame(1'b1, 1'b0, 32'h0);

      // Most-negative Q in d[0]
      load_frame(1);
      send_frame(31);
      recv_frame(1'b0, 1'b0, 32'h0);
`ifdef HERMITIAN_INSERTER_SAT_EN
      chk("x63_neg", got[63], 32'h0064_7FFF);
`else
      chk("x63_neg", got[63], 32'h0064_8000);
`endif
      chk("x1_raw", got[1], 32'h0064_8000);

      // Reset in the middle of a fill, then a different full frame
      load_frame(0);
      send_frame(10);
      @(negedge clk);
      s_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_s_ready", 32'(s_ready), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_m_valid", 32'(m_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready_after", 32'(s_ready), 32'd1);
      chk("midrst_m_valid_after", 32'(m_valid), 32'd0);
      load_frame(2);
      send_frame(31);
      recv_frame(1'b0, 1'b0, 32'h0);
      chk("b_x1", got[1], 32'h0007_FF38);
      chk("b_x63", got[63], 32'h0007_00C8);

      // Back-to-back frames, s_valid held high through the first emit
      send_frame(31);
      recv_frame(1'b0, 1'b1, 32'h0001_FFFF);
      load_frame(0);
      send_frame(31);
      chk("busy_len_b2b_1", busy_last, 66);
      recv_frame(1'b0, 1'b0, 32'h0);
      repeat (2) @(negedge clk);
      chk("busy_len_b2b_2", busy_last, 66);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
